// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage (fixed priority, never stalled) and a long-latency unit
// whose results wait in a small FIFO and drain into idle port cycles.
// Also provides WAW kill of superseded entries, a starvation stall request
// and a pending-destination query for the hazard unit.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wb_en,
    input  logic [4:0]                 wb_dest,
    input  logic [31:0]                wb_data,
    input  logic                       lu_valid,
    input  logic [4:0]                 lu_dest,
    input  logic [31:0]                lu_data,
    output logic                       lu_ready,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic                       stall_req,
    output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
    input  logic [4:0]                 query_addr,
    output logic                       query_hit
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SAT  = SW'(STARVE_LIMIT);

    // FIFO storage. A live bit is only ever set on an occupied slot and is
    // cleared when the slot pops, so live implies occupied.
    logic [DEPTH-1:0][4:0]  r_dest;
    logic [DEPTH-1:0][31:0] r_data;
    logic [DEPTH-1:0]       r_live;
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_cnt;

    // Port and starvation state
    logic                   r_we;
    logic [4:0]             r_waddr;
    logic [31:0]            r_wdata;
    logic [SW-1:0]          r_starve;
    logic                   r_stall;

    // Per-cycle decisions
    logic                   w_pw;
    logic                   w_empty;
    logic                   w_ready;
    logic                   w_head_live;
    logic                   w_pop_live;
    logic                   w_pop_dead;
    logic                   w_pop;
    logic                   w_push;
    logic [SW-1:0]          w_starve_nxt;
    logic [DEPTH-1:0]       w_kill;
    logic [DEPTH-1:0]       w_match;

    // Writes to $0 are discarded at the source; they never reach the port
    // and never kill anything.
    assign w_pw        = wb_en && (wb_dest != 5'd0);
    assign w_empty     = (r_cnt == '0);
    // Readiness depends on occupancy only, so a same-cycle pop cannot make
    // room for a same-cycle enqueue.
    assign w_ready     = (r_cnt < FULL);
    assign w_head_live = !w_empty && r_live[r_rptr];
    // A live head needs the port, so it yields to the pipeline; a dead head
    // needs no port slot and is discarded unconditionally.
    assign w_pop_live  = w_head_live && !w_pw;
    assign w_pop_dead  = !w_empty && !r_live[r_rptr];
    assign w_pop       = w_pop_live || w_pop_dead;
    // Results to $0, or to the register the pipeline writes this very cycle,
    // are already dead on arrival: accept the handshake, store nothing.
    assign w_push      = lu_valid && w_ready && (lu_dest != 5'd0) &&
                         !(w_pw && (lu_dest == wb_dest));

    // Per-entry destination compares for WAW kill and the hazard query
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_kill[g]  = w_pw && (r_dest[g] == wb_dest);
        assign w_match[g] = r_live[g] && (r_dest[g] == query_addr);
    end

    assign query_hit   = (query_addr != 5'd0) && (|w_match);
    assign lu_ready    = w_ready;
    assign pending_cnt = r_cnt;
    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign stall_req   = r_stall;

    // FIFO control: pointers, occupancy and live bits (kill, pop, push)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_live <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill[i]) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_live[r_rptr] <= 1'b0;
                r_rptr         <= r_rptr + PW'(1);
            end
            // The push slot is never the kill target nor the popped slot,
            // so this last assignment does not mask either of them.
            if (w_push) begin
                r_live[r_wptr] <= 1'b1;
                r_wptr         <= r_wptr + PW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO payload; contents are don't-care until marked live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dest[r_wptr] <= lu_dest;
            r_data[r_wptr] <= lu_data;
        end
    end

    // Port register: pipeline first, then a live FIFO head; address and
    // data hold when the port idles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
        end else if (w_pw) begin
            r_we    <= 1'b1;
            r_waddr <= wb_dest;
            r_wdata <= wb_data;
        end else if (w_pop_live) begin
            r_we    <= 1'b1;
            r_waddr <= r_dest[r_rptr];
            r_wdata <= r_data[r_rptr];
        end else begin
            r_we    <= 1'b0;
        end
    end

    // Next starvation count: cycles a live head has been blocked by the
    // pipeline, saturating at the limit
    always_comb begin
        w_starve_nxt = '0;
        if (!w_pop && w_head_live) begin
            w_starve_nxt = (r_starve == SAT) ? r_starve : r_starve + SW'(1);
        end
    end

    // Starvation counter and the registered stall request derived from it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt == SAT);
        end
    end

endmodule
